multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multicycle sequencer for the RV32I datapath: it replaces single-cycle opcode decoding with a Moore-style FSM. The FSM walks each instruction through fetch, decode, execute, memory and writeback, and drives the datapath mux selects and enables for each step. It stalls on a memory ready handshake and traps on unknown opcodes. It sits between the shared instruction/data memory port and the register file/ALU datapath.

## Interface
- CNT_W, 32, width of the optional performance counters
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- OpCode  in  7  instruction[6:0] from the instruction register
- Zero  in  1  ALU zero flag, used in BRANCH
- mem_ready  in  1  memory has completed the current read/write this cycle
- pc_write  out  1  load PC
- ir_write  out  1  load instruction register
- iord  out  1  memory address select: 0 = PC, 1 = ALU result register
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem_to_reg  out  1  writeback select: 1 = memory data register
- reg_write  out  1  register file write enable
- alu_src_a  out  2  0 = PC, 1 = rs1, 2 = old PC
- alu_src_b  out  2  0 = rs2, 1 = constant 4, 2 = immediate
- alu_op  out  2  00 add, 01 subtract/compare, 10 funct-decoded
- pc_src  out  1  0 = ALU result, 1 = ALU-out register (branch target)
- illegal  out  1  sticky trap flag
- state_o  out  4  current state encoding
- cycle_cnt  out  CNT_W  cycles since reset (see Configuration)
- instret_cnt  out  CNT_W  retired instructions (see Configuration)

## Operation
- State encodings: FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_LOAD = 3, WB_LOAD = 4, MEM_STORE = 5, EXEC_R = 6, WB_R = 7, BRANCH = 8, TRAP = 9.
- FETCH:
  - Outputs: mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 1, alu_op = 00.
  - ir_write and pc_write are asserted only when mem_ready = 1; the FSM then goes to DECODE, otherwise it stays in FETCH.
- DECODE:
  - Outputs: alu_src_a = 2, alu_src_b = 2, alu_op = 00 (branch target precompute).
  - Next state by OpCode: 0110011 → EXEC_R; 0000011 or 0100011 → MEM_ADDR; 1100011 → BRANCH; any other value → TRAP.
- MEM_ADDR:
  - Outputs: alu_src_a = 1, alu_src_b = 2, alu_op = 00.
  - Next state: MEM_LOAD for a load, MEM_STORE for a store.
- MEM_LOAD: mem_read = 1, iord = 1. Holds until mem_ready, then goes to WB_LOAD.
- WB_LOAD: reg_write = 1, mem_to_reg = 1. Next state is FETCH.
- MEM_STORE: mem_write = 1, iord = 1. Holds until mem_ready, then goes to FETCH.
- EXEC_R: alu_src_a = 1, alu_src_b = 0, alu_op = 10. Next state is WB_R.
- WB_R: reg_write = 1, mem_to_reg = 0. Next state is FETCH.
- BRANCH:
  - Outputs: alu_src_a = 1, alu_src_b = 0, alu_op = 01, pc_src = 1.
  - pc_write = Zero (the only Mealy output). Next state is FETCH.
- TRAP: all enables are 0 and illegal = 1. The FSM stays in TRAP until reset.
- Any output not listed for a state is 0.

## Timing
- Reset (asynchronous, rst_n low):
  - State goes to FETCH immediately.
  - illegal = 0; counters = 0.
  - Outputs take the FETCH values: mem_read = 1, alu_src_b = 1, all else 0.
- Cycle counts with mem_ready already high:
  - R-type: 4 cycles
  - Load: 5 cycles
  - Store: 4 cycles
  - Branch: 3 cycles
- Each cycle with mem_ready = 0 in FETCH, MEM_LOAD or MEM_STORE adds one cycle. mem_read/mem_write stay stable while waiting.
- mem_ready is ignored in every other state.
- Reset asserted mid-instruction aborts the instruction without any register or memory write. A write already issued in the same cycle is the memory's responsibility.
- OpCode is sampled only in DECODE and MEM_ADDR. It must be stable from DECODE until the FSM returns to FETCH.

## Configuration
- CTRL_PERF_CNT_EN defined:
  - cycle_cnt increments every cycle out of reset, including in TRAP.
  - instret_cnt increments on each transition into FETCH from WB_LOAD, MEM_STORE (on mem_ready), WB_R or BRANCH.
  - Both counters wrap modulo 2^CNT_W.
- CTRL_PERF_CNT_EN undefined: cycle_cnt and instret_cnt are tied to 0 and no counter flops are built.

## Test plan
- Reset, then R-type OpCode 0110011 with mem_ready held at 1 → state_o sequence 0, 1, 6, 7, 0; reg_write = 1 only in state 7; alu_op = 10 in state 6; with the macro, instret_cnt = 1.
- Load 0000011 with mem_ready low for 3 cycles in MEM_LOAD → 8 cycles total; mem_read = 1 and iord = 1 held throughout the wait; reg_write = 1 with mem_to_reg = 1 in state 4.
- Store 0100011 → mem_write = 1 exactly in state 5 until mem_ready; reg_write stays 0 throughout.
- Branch 1100011 with Zero = 1 → pc_write = 1 and pc_src = 1 in state 8. Repeat with Zero = 0 → pc_write = 0 in state 8.
- OpCode 0000000 in DECODE → state 9; illegal = 1 held for 20 cycles; rst_n low → illegal = 0 and state 0 asynchronously.
- rst_n asserted while in MEM_LOAD → state 0 before the next clock edge; no reg_write pulse; counters cleared.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle sequencer and the RV32I datapath/memory port.
// master = sequencer side, slave = datapath side.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       OpCode;
  logic             Zero;
  logic             mem_ready;
  logic             pc_write;
  logic             ir_write;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             mem_to_reg;
  logic             reg_write;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             pc_src;
  logic             illegal;
  logic [3:0]       state_o;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  modport master (
    input  OpCode, Zero, mem_ready,
    output pc_write, ir_write, iord, mem_read, mem_write, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, illegal, state_o, cycle_cnt, instret_cnt
  );

  modport slave (
    output OpCode, Zero, mem_ready,
    input  pc_write, ir_write, iord, mem_read, mem_write, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, illegal, state_o, cycle_cnt, instret_cnt
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I sequencer: fetch/decode/execute/memory/writeback FSM with trap state.
// Optional cycle/instret counters are built only when CTRL_PERF_CNT_EN is defined.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  multicycle_ctrl_if.master  bus
);

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_LOAD  = 4'd3,
    WB_LOAD   = 4'd4,
    MEM_STORE = 4'd5,
    EXEC_R    = 4'd6,
    WB_R      = 4'd7,
    BRANCH    = 4'd8,
    TRAP      = 4'd9
  } state_t;

  state_t state;
  state_t nextState;
  logic   retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= nextState;
  end

  always_comb begin
    nextState      = state;
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = 2'd0;
    bus.alu_src_b  = 2'd0;
    bus.alu_op     = 2'b00;
    bus.pc_src     = 1'b0;
    bus.illegal    = 1'b0;
    retire         = 1'b0;
    unique case (state)
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'd1;
        // Gated with rst_n so that reset presents pure FETCH defaults
        // even if the memory happens to report ready.
        if (bus.mem_ready && rst_n) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          nextState    = DECODE;
        end
      end
      DECODE: begin
        bus.alu_src_a = 2'd2;
        bus.alu_src_b = 2'd2;
        if (bus.OpCode == OP_RTYPE)                             nextState = EXEC_R;
        else if (bus.OpCode == OP_LOAD || bus.OpCode == OP_STORE) nextState = MEM_ADDR;
        else if (bus.OpCode == OP_BRANCH)                       nextState = BRANCH;
        else                                                    nextState = TRAP;
      end
      MEM_ADDR: begin
        bus.alu_src_a = 2'd1;
        bus.alu_src_b = 2'd2;
        nextState     = (bus.OpCode == OP_LOAD) ? MEM_LOAD : MEM_STORE;
      end
      MEM_LOAD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
        if (bus.mem_ready) nextState = WB_LOAD;
      end
      WB_LOAD: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        retire         = 1'b1;
        nextState      = FETCH;
      end
      MEM_STORE: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
        if (bus.mem_ready) begin
          retire    = 1'b1;
          nextState = FETCH;
        end
      end
      EXEC_R: begin
        bus.alu_src_a = 2'd1;
        bus.alu_op    = 2'b10;
        nextState     = WB_R;
      end
      WB_R: begin
        bus.reg_write = 1'b1;
        retire        = 1'b1;
        nextState     = FETCH;
      end
      BRANCH: begin
        bus.alu_src_a = 2'd1;
        bus.alu_op    = 2'b01;
        bus.pc_src    = 1'b1;
        bus.pc_write  = bus.Zero;
        retire        = 1'b1;
        nextState     = FETCH;
      end
      TRAP: begin
        // Absorbing until reset, so the trap flag stays sticky.
        bus.illegal = 1'b1;
        nextState   = TRAP;
      end
      default: nextState = TRAP;
    endcase
  end

  assign bus.state_o = state;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cycleCnt;
  logic [CNT_W-1:0] instretCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycleCnt   <= '0;
      instretCnt <= '0;
    end else begin
      cycleCnt <= cycleCnt + 1'b1;
      if (retire) instretCnt <= instretCnt + 1'b1;
    end
  end

  assign bus.cycle_cnt   = cycleCnt;
  assign bus.instret_cnt = instretCnt;
`else
  logic unusedRetire;
  assign unusedRetire    = retire;
  assign bus.cycle_cnt   = {CNT_W{1'b0}};
  assign bus.instret_cnt = {CNT_W{1'b0}};
`endif

endmodule
